estagio_busca: RTL

- Instruction-fetch stage with IF/ID pipeline register, directly upstream of unidade_controle.
- Holds the PC and issues one-outstanding requests to instruction memory over a req/ready + valid handshake.
- Presents the fetched instruction and its PC to decode. opcode_id drives unidade_controle.opcode.
- Handles decode stalls and taken-branch redirects. Every bubble carries instruction 32'h00000000, so unidade_controle sees opcode 7'b0000000 and drives all control signals to zero.

---
 rtl/estagio_busca.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/estagio_busca.sv
// Instruction fetch stage with IF/ID register; holds the PC and keeps at most one memory request in flight.
// Latency: with a zero-wait memory, an instruction reaches IF/ID two cycles after its request is issued; peak rate is one every 2 cycles.
// Backpressure: imem_req stays up with a stable address until imem_ready; stall freezes IF/ID and parks one response in a buffer.
module estagio_busca #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PASSO_PC = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic        valid_id,
    output logic [6:0]  opcode_id
);

    typedef enum logic [1:0] {INICIO, PEDIDO, ESPERA, RETEM} estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        descarte_q, descarte_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        valid_id_q, valid_id_d;

    // Redirect target is word aligned; the low two bits are dropped.
    logic [31:0] alvo;
    logic [31:0] prox_seq;
    assign alvo     = branch_target & ~32'd3;
    assign prox_seq = req_addr_q + PASSO_PC;

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= INICIO;
            pc_q        <= PC_RESET;
            req_addr_q  <= PC_RESET;
            descarte_q  <= 1'b0;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            instr_id_q  <= 32'd0;
            pc_id_q     <= 32'd0;
            valid_id_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            descarte_q  <= descarte_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_id_q  <= instr_id_d;
            pc_id_q     <= pc_id_d;
            valid_id_q  <= valid_id_d;
        end
    end

    // Next state: a redirect always returns to issuing, except that a request already presented must finish.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIO: estado_d = PEDIDO;
            PEDIDO: if (imem_ready) estado_d = ESPERA;
            ESPERA: begin
                if (imem_valid) begin
                    if (branch_taken || descarte_q || !stall) estado_d = PEDIDO;
                    else                                      estado_d = RETEM;
                end
            end
            RETEM: if (branch_taken || !stall) estado_d = PEDIDO;
            default: estado_d = INICIO;
        endcase
    end

    // Datapath: PC, request address, discard flag, stall buffer and IF/ID contents.
    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        descarte_d  = descarte_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_id_d  = instr_id_q;
        pc_id_d     = pc_id_q;
        valid_id_d  = valid_id_q;

        // Decode free and nothing new: insert a bubble, keeping pc_id.
        if (!stall) begin
            instr_id_d = 32'd0;
            valid_id_d = 1'b0;
        end
        // Redirect outranks stall: IF/ID is flushed regardless.
        if (branch_taken) begin
            instr_id_d = 32'd0;
            valid_id_d = 1'b0;
            pc_d       = alvo;
        end

        case (estado_q)
            INICIO: req_addr_d = branch_taken ? alvo : pc_q;
            PEDIDO: begin
                // The presented request cannot be withdrawn, so its answer is marked for dropping.
                if (branch_taken) descarte_d = 1'b1;
            end
            ESPERA: begin
                if (branch_taken) begin
                    if (imem_valid) begin
                        descarte_d = 1'b0;
                        req_addr_d = alvo;
                    end else begin
                        descarte_d = 1'b1;
                    end
                end else if (imem_valid) begin
                    if (descarte_q) begin
                        // pc already holds the redirect target.
                        descarte_d = 1'b0;
                        req_addr_d = pc_q;
                    end else if (!stall) begin
                        instr_id_d = imem_rdata;
                        pc_id_d    = req_addr_q;
                        valid_id_d = 1'b1;
                        pc_d       = prox_seq;
                        req_addr_d = prox_seq;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = req_addr_q;
                    end
                end
            end
            RETEM: begin
                if (branch_taken) begin
                    req_addr_d = alvo;
                end else if (!stall) begin
                    instr_id_d = buf_instr_q;
                    pc_id_d    = buf_pc_q;
                    valid_id_d = 1'b1;
                    pc_d       = buf_pc_q + PASSO_PC;
                    req_addr_d = buf_pc_q + PASSO_PC;
                end
            end
            default: ;
        endcase
    end

    // Outputs: the request is only raised while issuing; opcode comes straight off IF/ID.
    always_comb begin
        imem_req  = (estado_q == PEDIDO);
        imem_addr = req_addr_q;
        instr_id  = instr_id_q;
        pc_id     = pc_id_q;
        valid_id  = valid_id_q;
        opcode_id = instr_id_q[6:0];
    end

endmodule
